dbus_demux4: RTL and testbench

One-to-four data-bus request demultiplexer: accepts a single 64-bit request from the core-side bus and issues it to exactly one of four downstream ports chosen by a 2-bit select. It returns the selected port's response upstream, with a watchdog timeout. It sits between the memory stage and the memory-mapped targets (cache, MMIO, CLINT, spare). It is the issuing counterpart of the 4-input response select used elsewhere in the datapath.

---
 rtl/dbus_pkg.sv | 32 +++
 rtl/dbus_watchdog.sv | 31 +++
 rtl/dbus_demux4.sv | 146 ++++++++++++++
 tb/tb_dbus_demux4.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared types and constants for the one-to-four data-bus request demultiplexer.
package dbus_pkg;

    localparam int NPORTS = 4;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } dbus_state_t;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strobe;
    } dbus_req_t;

    // One-hot decode of a port index.
    function automatic logic [NPORTS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NPORTS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dbus_watchdog.sv
// Transaction watchdog: counts cycles while enabled and flags the last allowed cycle.
module dbus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Counter clears on a new request and saturates at the limit so it never wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Expire is decoded from the registered count only.
    assign o_expire = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/dbus_demux4.sv
// One-to-four data-bus request demultiplexer with registered response and watchdog.
module dbus_demux4
    import dbus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           up_valid,
    output logic                           up_ready,
    input  logic [SEL_W-1:0]               up_sel,
    input  logic [ADDR_W-1:0]              up_addr,
    input  logic [DATA_W-1:0]              up_wdata,
    input  logic [STRB_W-1:0]              up_strobe,
    output logic                           resp_valid,
    output logic [DATA_W-1:0]              resp_data,
    output logic                           resp_err,
    output logic [NPORTS-1:0]              dn_valid,
    output logic [ADDR_W-1:0]              dn_addr,
    output logic [DATA_W-1:0]              dn_wdata,
    output logic [STRB_W-1:0]              dn_strobe,
    input  logic [NPORTS-1:0]              dn_ready,
    input  logic [NPORTS-1:0]              dn_resp_valid,
    input  logic [NPORTS-1:0][DATA_W-1:0]  dn_resp_data,
    output logic                           stray_resp
);

    dbus_state_t       r_state;
    dbus_state_t       w_next;
    dbus_req_t         r_req;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;
    logic              r_stray;

    logic              w_accept;
    logic              w_active;
    logic              w_sel_ready;
    logic              w_sel_resp;
    logic              w_done;
    logic              w_expire;
    logic [NPORTS-1:0] w_own_mask;
    logic              w_stray_hit;

    assign w_accept    = (r_state == IDLE) && up_valid;
    assign w_active    = (r_state == ISSUE) || (r_state == WAIT);
    assign w_sel_ready = dn_ready[r_req.sel];
    assign w_sel_resp  = dn_resp_valid[r_req.sel];
    // A response completes the transaction only together with acceptance in ISSUE, or alone in WAIT.
    assign w_done      = ((r_state == ISSUE) && w_sel_ready && w_sel_resp) ||
                         ((r_state == WAIT) && w_sel_resp);
    // Outside ISSUE/WAIT no port owns the response channel, so every response is stray.
    assign w_own_mask  = w_active ? sel_onehot(r_req.sel) : '0;
    assign w_stray_hit = |(dn_resp_valid & ~w_own_mask);

    dbus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .i_clear  (w_accept),
        .i_enable (w_active),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; completion is tested before expiry so it wins a tie.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (up_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                if (w_done || w_expire) begin
                    w_next = RESP;
                end else if (w_sel_ready) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (w_done || w_expire) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Capture the request payload on acceptance; it drives the downstream bus until the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req <= '0;
        end else if (w_accept) begin
            r_req <= '{sel: up_sel, addr: up_addr, wdata: up_wdata, strobe: up_strobe};
        end
    end

    // Register the response on entry to RESP and hold it until the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else if (w_done) begin
            r_resp_data <= dn_resp_data[r_req.sel];
            r_resp_err  <= 1'b0;
        end else if (w_expire) begin
            r_resp_data <= '1;
            r_resp_err  <= 1'b1;
        end
    end

    // Sticky stray-response flag, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stray <= 1'b0;
        end else if (w_stray_hit) begin
            r_stray <= 1'b1;
        end
    end

    assign up_ready   = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign dn_valid   = (r_state == ISSUE) ? sel_onehot(r_req.sel) : '0;
    assign dn_addr    = r_req.addr;
    assign dn_wdata   = r_req.wdata;
    assign dn_strobe  = r_req.strobe;
    assign stray_resp = r_stray;

endmodule

// File: tb/tb_dbus_demux4.sv
// Self-checking bench for dbus_demux4: directed and randomized transactions against a timing model.
module tb_dbus_demux4;

    localparam int TO = 10;

    logic              clk = 1'b0;
    logic              resetn;
    logic              up_valid;
    logic              up_ready;
    logic [1:0]        up_sel;
    logic [63:0]       up_addr;
    logic [63:0]       up_wdata;
    logic [7:0]        up_strobe;
    logic              resp_valid;
    logic [63:0]       resp_data;
    logic              resp_err;
    logic [3:0]        dn_valid;
    logic [63:0]       dn_addr;
    logic [63:0]       dn_wdata;
    logic [7:0]        dn_strobe;
    logic [3:0]        dn_ready;
    logic [3:0]        dn_resp_valid;
    logic [3:0][63:0]  dn_resp_data;
    logic              stray_resp;

    int   checks = 0;
    int   errors = 0;
    logic exp_stray = 1'b0;

    dbus_demux4 #(.TIMEOUT(TO)) u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .up_valid      (up_valid),
        .up_ready      (up_ready),
        .up_sel        (up_sel),
        .up_addr       (up_addr),
        .up_wdata      (up_wdata),
        .up_strobe     (up_strobe),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .dn_valid      (dn_valid),
        .dn_addr       (dn_addr),
        .dn_wdata      (dn_wdata),
        .dn_strobe     (dn_strobe),
        .dn_ready      (dn_ready),
        .dn_resp_valid (dn_resp_valid),
        .dn_resp_data  (dn_resp_data),
        .stray_resp    (stray_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_resp_data();
        for (int i = 0; i < 4; i++) begin
            dn_resp_data[i] = {$urandom, $urandom};
        end
    endtask

    // One transaction. Entered just after a falling edge with the DUT idle; returns just after
    // the falling edge of the first idle cycle following the response.
    // Ready arrives 1+rdly cycles after accept; the response rspdly cycles after ready
    // (same cycle when 0). Completion must land within TO cycles of accept, otherwise an error
    // response appears TO+1 cycles after accept.
    task automatic run_txn(input logic [1:0] sel, input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] strb, input int rdly, input int rspdly, input bit never,
                           input logic [63:0] rdata, input int stray_k, input bit hold_valid);
        int         r_rel;
        int         c_rel;
        int         rc_rel;
        bit         tmo;
        logic [3:0] oh;
        logic [63:0] exp_data;
        oh       = 4'b0001 << sel;
        r_rel    = 1 + rdly;
        c_rel    = r_rel + rspdly;
        tmo      = never || (c_rel > TO);
        rc_rel   = tmo ? TO + 1 : c_rel + 1;
        exp_data = tmo ? 64'hFFFF_FFFF_FFFF_FFFF : rdata;

        chk("start_up_ready", {63'd0, up_ready}, 64'd1);
        up_valid      = 1'b1;
        up_sel        = sel;
        up_addr       = addr;
        up_wdata      = wdata;
        up_strobe     = strb;
        dn_ready      = 4'b0;
        dn_resp_valid = 4'b0;
        randomize_resp_data();

        for (int k = 1; k <= rc_rel + 1; k++) begin
            @(negedge clk);
            if (!hold_valid) up_valid = 1'b0;
            chk("stray_resp", {63'd0, stray_resp}, {63'd0, exp_stray});
            chk("dn_valid", {60'd0, dn_valid}, (k <= r_rel && k < rc_rel) ? {60'd0, oh} : 64'd0);
            chk("up_ready", {63'd0, up_ready}, (k > rc_rel) ? 64'd1 : 64'd0);
            chk("resp_valid", {63'd0, resp_valid}, (k == rc_rel) ? 64'd1 : 64'd0);
            chk("dn_addr", dn_addr, addr);
            chk("dn_wdata", dn_wdata, wdata);
            chk("dn_strobe", {56'd0, dn_strobe}, {56'd0, strb});
            if (k >= rc_rel) begin
                chk("resp_data", resp_data, exp_data);
                chk("resp_err", {63'd0, resp_err}, {63'd0, tmo});
            end
            dn_ready      = 4'b0;
            dn_resp_valid = 4'b0;
            randomize_resp_data();
            if (k <= rc_rel) begin
                if (k == r_rel) dn_ready = oh;
                if (!tmo && k == c_rel) begin
                    dn_resp_valid     = oh;
                    dn_resp_data[sel] = rdata;
                end
                if (k == stray_k) begin
                    dn_resp_valid[2'(sel + 2'd1)] = 1'b1;
                    exp_stray = 1'b1;
                end
            end
        end
    endtask

    initial begin
        int n_rand;
        resetn        = 1'b0;
        up_valid      = 1'b0;
        up_sel        = 2'd0;
        up_addr       = 64'd0;
        up_wdata      = 64'd0;
        up_strobe     = 8'd0;
        dn_ready      = 4'b0;
        dn_resp_valid = 4'b0;
        dn_resp_data  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_up_ready", {63'd0, up_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_dn_valid", {60'd0, dn_valid}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_dn_addr", dn_addr, 64'd0);
        chk("rst_stray", {63'd0, stray_resp}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single-cycle read on port 2.
        run_txn(2'd2, 64'h8000_0010, 64'h0, 8'h00, 0, 0, 1'b0, 64'hDEAD_BEEF, -1, 1'b0);
        // Write on port 1 with delayed ready and response.
        run_txn(2'd1, 64'h0000_1234_5678_0040, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 3, 5, 1'b0,
                64'h0123_4567_89AB_CDEF, -1, 1'b0);
        // Port 3 never responds: error response.
        run_txn(2'd3, 64'h0200_BFF8, 64'h0, 8'h00, 2, 0, 1'b1, 64'h0, -1, 1'b0);
        // Stray response from port 1 while port 0 is waiting.
        run_txn(2'd0, 64'h0000_0000_1000_0000, 64'h0, 8'h00, 0, 4, 1'b0, 64'h1111_2222_3333_4444, 3, 1'b0);
        // Completion on the last allowed cycle wins over timeout; one cycle later times out.
        run_txn(2'd1, 64'h40, 64'h0, 8'h00, 4, 5, 1'b0, 64'h5555_AAAA_5555_AAAA, -1, 1'b0);
        run_txn(2'd2, 64'h48, 64'h0, 8'h00, 4, 6, 1'b0, 64'h7777_8888_9999_0000, -1, 1'b0);
        // Ready and response together on the last allowed cycle.
        run_txn(2'd0, 64'h50, 64'h0, 8'h0F, 9, 0, 1'b0, 64'hCAFE_F00D_CAFE_F00D, -1, 1'b0);
        // Back-to-back with up_valid held high.
        run_txn(2'd0, 64'h100, 64'h1, 8'h01, 0, 0, 1'b0, 64'hAAAA, -1, 1'b1);
        run_txn(2'd3, 64'h108, 64'h2, 8'h03, 0, 0, 1'b0, 64'hBBBB, -1, 1'b1);
        run_txn(2'd1, 64'h110, 64'h3, 8'h07, 0, 0, 1'b0, 64'hCCCC, -1, 1'b0);

        // Reset during WAIT, then a late response after reset.
        up_valid = 1'b1;
        up_sel   = 2'd0;
        up_addr  = 64'h2000;
        up_wdata = 64'h0;
        up_strobe = 8'h00;
        @(negedge clk);
        up_valid = 1'b0;
        dn_ready = 4'b0001;
        @(negedge clk);
        dn_ready = 4'b0000;
        chk("wait_dn_valid", {60'd0, dn_valid}, 64'd0);
        chk("wait_up_ready", {63'd0, up_ready}, 64'd0);
        resetn = 1'b0;
        #1;
        exp_stray = 1'b0;
        chk("midrst_dn_valid", {60'd0, dn_valid}, 64'd0);
        chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("midrst_up_ready", {63'd0, up_ready}, 64'd1);
        chk("midrst_stray", {63'd0, stray_resp}, 64'd0);
        chk("midrst_dn_addr", dn_addr, 64'd0);
        chk("midrst_resp_err", {63'd0, resp_err}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        dn_resp_valid = 4'b0001;
        @(negedge clk);
        dn_resp_valid = 4'b0000;
        exp_stray = 1'b1;
        chk("late_stray", {63'd0, stray_resp}, 64'd1);
        chk("late_up_ready", {63'd0, up_ready}, 64'd1);
        chk("late_resp_valid", {63'd0, resp_valid}, 64'd0);

        // Randomized transactions.
        n_rand = 40;
        for (int t = 0; t < n_rand; t++) begin
            logic [1:0] s;
            int         rd;
            int         rs;
            bit         nv;
            int         sk;
            bit         hv;
            s  = 2'($urandom_range(0, 3));
            rd = int'($urandom_range(0, 6));
            rs = int'($urandom_range(0, 6));
            nv = ($urandom_range(0, 7) == 0);
            sk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
            hv = 1'($urandom_range(0, 1));
            run_txn(s, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), rd, rs, nv,
                    {$urandom, $urandom}, sk, hv);
        end
        up_valid = 1'b0;
        @(negedge clk);
        chk("final_up_ready", {63'd0, up_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
